// File: rtl/serial_adder_ctrl_pkg.sv
// Shared types for the bit-serial add controller: FSM state encoding and
// the signed-overflow helper.
package serial_adder_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Two's-complement overflow: carry into the MSB differs from carry out of it.
    function automatic logic signed_ovf(input logic carry_into_msb, input logic carry_out);
        return carry_into_msb ^ carry_out;
    endfunction

endpackage

// File: rtl/serial_adder_ctrl_one_bit_adder_nand.sv
// One-bit full adder built only from 2-input NAND gates; purely combinational.
module one_bit_adder_nand (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic n1_s;
    logic n2_s;
    logic n3_s;
    logic x1_s;
    logic n4_s;
    logic n5_s;
    logic n6_s;

    // Classic nine-NAND full adder; x1_s is a^b, cout reuses n1_s and n4_s.
    always_comb begin
        n1_s = ~(a & b);
        n2_s = ~(a & n1_s);
        n3_s = ~(b & n1_s);
        x1_s = ~(n2_s & n3_s);
        n4_s = ~(x1_s & cin);
        n5_s = ~(x1_s & n4_s);
        n6_s = ~(cin & n4_s);
        s    = ~(n5_s & n6_s);
        cout = ~(n1_s & n4_s);
    end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: feeds one NAND full-adder cell LSB first over
// WIDTH cycles, chaining the carry through a register.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_MSB  = CW'(WIDTH - 2);

    state_e           state_q,  state_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic [WIDTH-1:0] op_a_q,   op_a_d;
    logic [WIDTH-1:0] op_b_q,   op_b_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
    logic             carry_q,  carry_d;
    logic             cmsb_q,   cmsb_d;
    logic [WIDTH-1:0] sum_q,    sum_d;
    logic             cout_q,   cout_d;
    logic             ovf_q,    ovf_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;

    logic add_s;
    logic add_co;

    one_bit_adder_nand u_cell (
        .a    (op_a_q[0]),
        .b    (op_b_q[0]),
        .cin  (carry_q),
        .s    (add_s),
        .cout (add_co)
    );

    // Next-state, datapath shifting and result capture.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        sum_sh_d = sum_sh_q;
        carry_d  = carry_q;
        cmsb_d   = cmsb_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    op_a_d  = a;
                    op_b_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                op_a_d   = op_a_q >> 1;
                op_b_d   = op_b_q >> 1;
                sum_sh_d = {add_s, sum_sh_q[WIDTH-1:1]};
                carry_d  = add_co;
                // The carry leaving bit WIDTH-2 is the carry into the MSB.
                if (cnt_q == CNT_MSB) begin
                    cmsb_d = add_co;
                end else begin
                    cmsb_d = cmsb_q;
                end
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                    sum_d   = {add_s, sum_sh_q[WIDTH-1:1]};
                    cout_d  = add_co;
                    ovf_d   = signed_ovf(cmsb_q, add_co);
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            sum_sh_q <= '0;
            carry_q  <= 1'b0;
            cmsb_q   <= 1'b0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            sum_sh_q <= sum_sh_d;
            carry_q  <= carry_d;
            cmsb_q   <= cmsb_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl at WIDTH=8: hand-computed vectors,
// start-in-RUN, back-to-back, mid-run reset and a strided operand sweep.
module tb_serial_adder_ctrl;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;
    logic       overflow;

    int total;
    int bad;

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .clock    (clk),
        .reset    (reset),
        .start    (start),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One full operation; expected values given explicitly by the caller.
    task automatic op_exp(input string tag, input logic [7:0] av, input logic [7:0] bv,
                          input logic cv, input logic [7:0] es, input logic ec, input logic eo);
        int bn;
        int n;
        @(negedge clk);
        a = av; b = bv; cin = cv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
        bn = 0;
        n  = 0;
        while (!done && n < 20) begin
            if (busy) bn++;
            @(negedge clk);
            n++;
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busycyc"}, 32'(bn), 32'd8);
        chk({tag, "_sum"}, 32'(sum), 32'(es));
        chk({tag, "_cout"}, 32'(cout), 32'(ec));
        chk({tag, "_ovf"}, 32'(overflow), 32'(eo));
        @(negedge clk);
        chk({tag, "_donedrop"}, 32'(done), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    // Same, with expectations from plain integer arithmetic.
    task automatic op_model(input string tag, input logic [7:0] av, input logic [7:0] bv, input logic cv);
        logic [8:0] e;
        logic       eo;
        e  = {1'b0, av} + {1'b0, bv} + {8'd0, cv};
        eo = (av[7] == bv[7]) && (e[7] != av[7]);
        op_exp(tag, av, bv, cv, e[7:0], e[8], eo);
    endtask

    initial begin
        int dn;
        int di;
        int t1;
        int t2;
        logic [7:0] s1;
        logic [7:0] s2;
        logic [7:0] sv;
        logic nb;

        total = 0;
        bad   = 0;
        reset = 1'b1;
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        cin   = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum",  32'(sum),  32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_ovf",  32'(overflow), 32'd0);
        reset = 1'b0;

        op_exp("zero",   8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        op_exp("ff_01",  8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        op_exp("0f_0f",  8'h0F, 8'h0F, 1'b1, 8'h1F, 1'b0, 1'b0);
        op_exp("7f_01",  8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        op_exp("80_80",  8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
        op_exp("ff_ff1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);

        // start raised mid-RUN with new operands must be ignored
        @(negedge clk);
        a = 8'h03; b = 8'h04; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dn = 0; di = -1; sv = 8'h00;
        for (int i = 0; i < 13; i++) begin
            if (done) begin
                dn++;
                di = i;
                sv = sum;
            end
            if (i == 2) begin
                start = 1'b1; a = 8'h55; b = 8'hAA;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        chk("ign_pulses", 32'(dn), 32'd1);
        chk("ign_sum",    32'(sv), 32'h07);
        chk("ign_lat",    32'(di), 32'd8);
        chk("ign_idle",   32'(busy), 32'd0);

        // start held through DONE: next op starts without an IDLE cycle
        @(negedge clk);
        a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
        t1 = -1; t2 = -1; s1 = 8'h00; s2 = 8'h00; nb = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) begin
                if (t1 < 0) begin
                    t1 = i; s1 = sum; a = 8'h01; b = 8'h02;
                end else if (t2 < 0) begin
                    t2 = i; s2 = sum;
                end
            end
            if (t1 >= 0 && i == t1 + 1) begin
                nb = busy;
                start = 1'b0;
            end
        end
        chk("b2b_sum1",   32'(s1), 32'h30);
        chk("b2b_sum2",   32'(s2), 32'h03);
        chk("b2b_space",  32'(t2 - t1), 32'd9);
        chk("b2b_noidle", 32'(nb), 32'd1);
        start = 1'b0;

        // reset in RUN cycle 4 aborts and clears results
        op_exp("pre_rst", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        @(negedge clk);
        a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        chk("mrst_sum",  32'(sum),  32'd0);
        chk("mrst_cout", 32'(cout), 32'd0);
        chk("mrst_ovf",  32'(overflow), 32'd0);
        reset = 1'b0;
        dn = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("mrst_nopulse", 32'(dn), 32'd0);
        op_exp("post_rst", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);

        // strided sweep against integer arithmetic
        for (int i = 0; i < 256; i += 17) begin
            for (int j = 0; j < 256; j += 17) begin
                for (int c = 0; c < 2; c++) begin
                    op_model("sweep", 8'(i), 8'(j), 1'(c));
                end
            end
        end
        op_model("sweep_80_7f", 8'h80, 8'h7F, 1'b1);
        op_model("sweep_c0_c0", 8'hC0, 8'hC0, 1'b0);
        op_model("sweep_40_40", 8'h40, 8'h40, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
